// File: rtl/expr_accum.sv
// rtl/expr_accum.sv - streaming fp32 vector accumulator with interleaved partial sums (optional EXPR_ACCUM_COUNT_EN adds out_count_o)

// Pipelined IEEE-754 single-precision adder, round-to-nearest-even, result LAT cycles after issue.
module fp_add #(
    parameter int LAT = 4
) (
    input  logic        clk_i,
    input  logic        areset_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] q_o
);
    logic [31:0] pipe_q [LAT];

    function automatic logic [31:0] add_f(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] big, sml;
        logic [7:0]  eb, es, d;
        logic [26:0] mb, ms, m;
        logic [53:0] wide;
        logic [27:0] s;
        logic [9:0]  e;
        logic [24:0] rm;
        logic        up;
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
            if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0) ||
                (x[30:23] == 8'hFF && y[30:23] == 8'hFF && x[31] != y[31]))
                return 32'h7FC00000;
            return (x[30:23] == 8'hFF) ? x : y;
        end
        if (x[30:0] >= y[30:0]) begin
            big = x; sml = y;
        end else begin
            big = y; sml = x;
        end
        // Subnormals use effective exponent 1 with no hidden bit.
        eb = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
        es = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
        mb = {big[30:23] != 8'd0, big[22:0], 3'b000};
        ms = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
        d  = eb - es;
        if (d > 8'd27) d = 8'd27;
        wide = {ms, 27'd0} >> d;
        ms   = wide[53:27] | {26'd0, |wide[26:0]};
        s = (big[31] ^ sml[31]) ? ({1'b0, mb} - {1'b0, ms}) : ({1'b0, mb} + {1'b0, ms});
        // Exact cancellation yields +0; only -0 + -0 stays negative.
        if (s == 28'd0) return {big[31] & sml[31], 31'd0};
        e = {2'b00, eb};
        if (s[27]) begin
            m = s[27:1] | {26'd0, s[0]};
            e = e + 10'd1;
        end else begin
            m = s[26:0];
            for (int i = 0; i < 26; i++) begin
                if (!m[26] && e > 10'd1) begin
                    m = {m[25:0], 1'b0};
                    e = e - 10'd1;
                end
            end
        end
        up = m[2] & (m[1] | m[0] | m[3]);
        rm = {1'b0, m[26:3]} + {24'd0, up};
        if (rm[24]) begin
            rm = rm >> 1;
            e  = e + 10'd1;
        end
        if (e >= 10'd255) return {big[31], 8'hFF, 23'd0};
        return {big[31], rm[23] ? e[7:0] : 8'd0, rm[22:0]};
    endfunction

    // Compute in the first stage, then carry the result down the delay line.
    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= 32'd0;
        end else begin
            pipe_q[0] <= add_f(a_i, b_i);
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[LAT-1];
endmodule

module expr_accum #(
    parameter int ADD_LAT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_data_i,
    input  logic        in_last_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    output logic [31:0] out_sum_o,
    output logic        drop_err_o
`ifdef EXPR_ACCUM_COUNT_EN
    ,
    output logic [15:0] out_count_o
`endif
);
    typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_REDUCE, S_DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(ADD_LAT - 1);
    localparam logic [3:0] K_MAX    = 4'(ADD_LAT);
    localparam int         PS1      = (ADD_LAT > 1) ? 1 : 0;

    state_t                  state_q;
    logic [ADD_LAT-1:0]      ring_q;
    logic [ADD_LAT*32-1:0]   psum_q;
    logic [3:0]              cnt_q, k_q;
    logic                    in_ready_q, out_valid_q, drop_err_q;
    logic [31:0]             out_sum_q;
    logic [31:0]             add_a_d, add_b_d, add_q, cap_d;
    logic                    tail, accept, finish_d;
`ifdef EXPR_ACCUM_COUNT_EN
    logic [15:0]             elem_cnt_q, out_count_q;
`endif

    fp_add #(.LAT(ADD_LAT)) u_add (
        .clk_i    (clk_i),
        .areset_i (reset_i),
        .a_i      (add_a_d),
        .b_i      (add_b_d),
        .q_o      (add_q)
    );

    assign tail   = ring_q[ADD_LAT-1];
    assign cap_d  = tail ? add_q : 32'd0;
    assign accept = in_valid_i & in_ready_q;

    // Adder operand selection: feedback loop while accumulating, chained pair-sums while reducing.
    always_comb begin
        add_a_d  = 32'd0;
        add_b_d  = 32'd0;
        finish_d = 1'b0;
        case (state_q)
            S_ACCUM: begin
                add_a_d = accept ? in_data_i : 32'd0;
                add_b_d = cap_d;
            end
            S_DRAIN: begin
                if (cnt_q == LAST_CNT) begin
                    if (ADD_LAT == 1) begin
                        finish_d = 1'b1;
                    end else begin
                        // The last slot is still being captured, so forward it directly.
                        add_a_d = psum_q[31:0];
                        add_b_d = (ADD_LAT == 2) ? cap_d : psum_q[PS1*32 +: 32];
                    end
                end
            end
            S_REDUCE: begin
                if (cnt_q == LAST_CNT) begin
                    if (k_q == K_MAX) begin
                        finish_d = 1'b1;
                    end else begin
                        add_a_d = add_q;
                        add_b_d = psum_q[k_q*32 +: 32];
                    end
                end
            end
            default: ;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_ACCUM;
            ring_q      <= '0;
            psum_q      <= '0;
            cnt_q       <= 4'd0;
            k_q         <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= 32'd0;
            drop_err_q  <= 1'b0;
`ifdef EXPR_ACCUM_COUNT_EN
            elem_cnt_q  <= 16'd0;
            out_count_q <= 16'd0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            if (in_valid_i && !in_ready_q) drop_err_q <= 1'b1;
            if (finish_d) begin
                state_q     <= S_DONE;
                out_valid_q <= 1'b1;
                out_sum_q   <= (state_q == S_DRAIN) ? cap_d : add_q;
`ifdef EXPR_ACCUM_COUNT_EN
                out_count_q <= elem_cnt_q;
`endif
            end
            case (state_q)
                S_ACCUM: begin
                    ring_q <= (ring_q << 1) | ADD_LAT'(accept | tail);
`ifdef EXPR_ACCUM_COUNT_EN
                    if (accept && elem_cnt_q != 16'hFFFF) elem_cnt_q <= elem_cnt_q + 16'd1;
`endif
                    if (accept && in_last_i) begin
                        state_q    <= S_DRAIN;
                        in_ready_q <= 1'b0;
                        cnt_q      <= 4'd0;
                    end
                end
                S_DRAIN: begin
                    ring_q                 <= ring_q << 1;
                    psum_q[cnt_q*32 +: 32] <= cap_d;
                    cnt_q                  <= cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT && ADD_LAT > 1) begin
                        state_q <= S_REDUCE;
                        cnt_q   <= 4'd0;
                        k_q     <= 4'd2;
                    end
                end
                S_REDUCE: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_q <= 4'd0;
                        k_q   <= k_q + 4'd1;
                    end
                end
                default: begin
                    state_q    <= S_ACCUM;
                    ring_q     <= '0;
                    in_ready_q <= 1'b1;
`ifdef EXPR_ACCUM_COUNT_EN
                    elem_cnt_q <= 16'd0;
`endif
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_sum_o   = out_sum_q;
    assign drop_err_o  = drop_err_q;
`ifdef EXPR_ACCUM_COUNT_EN
    assign out_count_o = out_count_q;
`endif
endmodule

// File: tb/tb_expr_accum.sv
// tb/tb_expr_accum.sv - randomized self-checking bench for expr_accum against an exact-arithmetic sum model
module tb_expr_accum;
    localparam int L = 4;

    logic        clk;
    logic        reset_i;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_last_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_sum_o;
    logic        drop_err_o;
`ifdef EXPR_ACCUM_COUNT_EN
    logic [15:0] out_count_o;
`endif

    int  n_checks;
    int  n_errors;
    bit  exp_drop;
    logic [31:0] last_sum;
    real vec_q[$];
    int  gap_q[$];

    expr_accum #(.ADD_LAT(L)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_sum_o   (out_sum_o),
        .drop_err_o  (drop_err_o)
`ifdef EXPR_ACCUM_COUNT_EN
        ,
        .out_count_o (out_count_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exactly representable reals only (small multiples of 0.25).
    function automatic logic [31:0] to_f32(input real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        e = b[62:52];
        return {b[63], 8'(e - 11'd896), b[51:29]};
    endfunction

    // Drive vec_q with gap_q idle cycles before each element, then wait for the result.
    task automatic run_vector(input string tag, input bit inject_drop, input bit inject_reset);
        real sum;
        bit  done;
        int  n;
        sum = 0.0;
        for (int i = 0; i < vec_q.size(); i++) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                @(negedge clk);
                in_valid_i = 1'b0; in_last_i = 1'b0; in_data_i = 32'd0;
            end
            @(negedge clk);
            chk({tag, "_ready"}, {31'd0, in_ready_o}, 32'd1);
            in_valid_i = 1'b1;
            in_data_i  = to_f32(vec_q[i]);
            in_last_i  = (i == vec_q.size() - 1);
            sum += vec_q[i];
        end
        done = 1'b0;
        n = 1;
        while (!done && n <= L*L + 6) begin
            @(negedge clk);
            if (n == 1 || (inject_drop && n == 4)) begin
                in_valid_i = 1'b0; in_last_i = 1'b0; in_data_i = 32'd0;
            end
            if (inject_drop && n == 3) begin
                in_valid_i = 1'b1; in_data_i = 32'h4479C000; in_last_i = 1'b1;
                exp_drop = 1'b1;
            end
            if (inject_reset && n == 5) begin
                reset_i = 1'b1;
                exp_drop = 1'b0;
                #1;
                chk({tag, "_rst_valid"}, {31'd0, out_valid_o}, 32'd0);
                chk({tag, "_rst_ready"}, {31'd0, in_ready_o}, 32'd1);
                chk({tag, "_rst_sum"}, out_sum_o, 32'd0);
                chk({tag, "_rst_drop"}, {31'd0, drop_err_o}, 32'd0);
                @(negedge clk);
                reset_i = 1'b0;
                done = 1'b1;
            end else if (out_valid_o) begin
                done = 1'b1;
                last_sum = to_f32(sum);
                chk({tag, "_latency"}, n, L*L + 1);
                chk({tag, "_sum"}, out_sum_o, last_sum);
                chk({tag, "_busy"}, {31'd0, in_ready_o}, 32'd0);
                chk({tag, "_drop"}, {31'd0, drop_err_o}, {31'd0, exp_drop});
`ifdef EXPR_ACCUM_COUNT_EN
                chk({tag, "_count"}, {16'd0, out_count_o}, vec_q.size());
`endif
            end
            n++;
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clk = 1'b0; reset_i = 1'b1;
        in_valid_i = 1'b0; in_data_i = 32'd0; in_last_i = 1'b0;
        n_checks = 0; n_errors = 0; exp_drop = 1'b0; last_sum = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'd0, in_ready_o}, 32'd1);
        chk("reset_valid", {31'd0, out_valid_o}, 32'd0);
        chk("reset_sum", out_sum_o, 32'd0);
        chk("reset_drop", {31'd0, drop_err_o}, 32'd0);
        reset_i = 1'b0;

        vec_q = '{1.0, 2.0, 3.0, 4.0}; gap_q = '{0, 0, 0, 0};
        run_vector("v1234", 1'b0, 1'b0);
        @(negedge clk);
        chk("v1234_pulse_end", {31'd0, out_valid_o}, 32'd0);
        chk("v1234_hold", out_sum_o, last_sum);
        chk("v1234_ready_back", {31'd0, in_ready_o}, 32'd1);

        vec_q = '{-3.0}; gap_q = '{0};
        run_vector("single", 1'b0, 1'b0);

        vec_q = '{1.0, 1.0, 1.0}; gap_q = '{0, 2, 2};
        run_vector("gaps", 1'b0, 1'b0);

        vec_q = '{}; gap_q = '{};
        for (int i = 0; i < 10; i++) begin vec_q.push_back(0.5); gap_q.push_back(0); end
        run_vector("drop", 1'b1, 1'b0);

        vec_q = '{1.0, 2.0, 3.0, 5.0, 7.0}; gap_q = '{0, 0, 0, 0, 0};
        run_vector("reset_mid", 1'b0, 1'b1);
        vec_q = '{2.0, 2.0}; gap_q = '{0, 0};
        run_vector("after_rst", 1'b0, 1'b0);

        vec_q = '{1.0}; gap_q = '{0};
        run_vector("b2b_a", 1'b0, 1'b0);
        vec_q = '{8.0, 8.0}; gap_q = '{0, 0};
        run_vector("b2b_b", 1'b0, 1'b0);

        for (int v = 0; v < 20; v++) begin
            int len;
            len = $urandom_range(1, 20);
            vec_q = '{}; gap_q = '{};
            for (int i = 0; i < len; i++) begin
                vec_q.push_back(real'(int'($urandom_range(0, 128)) - 64) * 0.25);
                gap_q.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
            run_vector($sformatf("rand%0d", v), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/expr_accum.md
# expr_accum

Streaming single-precision floating-point accumulator that sits directly downstream of the `expr` pipeline. It consumes one `expr` result per cycle, tagged valid by the issuing logic, and sums a vector of results terminated by a last flag. It returns one IEEE-754 single-precision sum per vector. It hides the `fp_add` loop latency by keeping ADD_LAT interleaved partial sums in flight, then reduces them serially once the vector ends.

## Interface
- ADD_LAT, 4: latency in cycles of the instantiated `fp_add` core. Must match the core configuration; legal range 1–8.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset; also drives `fp_add` `areset`.
- in_valid  in  1  `in_data` carries an element this cycle.
- in_data  in  32  single-precision element (the `expr` result).
- in_last  in  1  with `in_valid`, marks the final element of the vector.
- in_ready  out  1  block can accept elements; reset value 1.
- out_valid  out  1  one-cycle pulse when `out_sum` is valid; reset value 0.
- out_sum  out  32  vector sum; holds its value until the next pulse; reset value 0.
- drop_err  out  1  sticky; set when an element is offered while `in_ready`=0; reset value 0.

## Operation
- Single `fp_add` instance.
- ACCUM loop:
  - Input a = `in_data` if accepted, else +0.
  - Input b = q if `ring_vld[tail]`, else +0.
  - `ring_vld` is an ADD_LAT-bit shift register marking live partial sums.
  - An element issued in cycle c joins partial sum (c − c0) mod ADD_LAT, where c0 is the first cycle of the vector.
- States and transitions:
  - ACCUM (reset state): accept while `in_valid`. Accepting with `in_last`=1 → DRAIN, and `in_ready` drops to 0 the next cycle.
  - DRAIN: ADD_LAT cycles; a=+0, b=+0 (loop broken); capture q into psum[0..ADD_LAT−1]. Slots whose `ring_vld` was clear are captured as +0. → REDUCE.
  - REDUCE: acc=psum[0]; for k=1..ADD_LAT−1, issue acc+psum[k] and wait ADD_LAT cycles for each result. → DONE. With ADD_LAT=1, go straight to DONE.
  - DONE: register the result into `out_sum`, pulse `out_valid`, clear `ring_vld`, raise `in_ready`. → ACCUM.
- `in_valid` with `in_ready`=0: element discarded, `drop_err` set, state unaffected.
- A single-element vector (`in_valid` & `in_last` on the first element) yields that element exactly.
- NaN and Inf propagate per `fp_add`; no special handling.
- Reset mid-operation clears state, `ring_vld`, psum and outputs immediately. The `fp_add` pipeline is reset in parallel.

## Timing
- Let T be the cycle `in_last` is accepted and L = ADD_LAT.
- `in_ready` is 0 from T+1 through the DONE cycle. It is 1 again in the cycle after `out_valid`.
- `out_valid` is high exactly in cycle T + L² + 1. For L=4 that is T+17; for L=1, T+2.
- Throughput during ACCUM: one element per cycle, no bubbles required. Gaps are allowed and add +0.
- Minimum spacing between vector ends: L² + 2 cycles.

## Configuration
- `EXPR_ACCUM_COUNT_EN` defined:
  - Adds output `out_count` [15:0]: number of elements accepted in the vector.
  - Valid with `out_valid`; reset value 0.
  - Saturates at 16'hFFFF.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Vector 1.0, 2.0, 3.0, 4.0 on consecutive cycles with last on 4.0 (L=4) → `out_sum`=32'h41200000 (10.0), `out_valid` exactly 17 cycles after the last element; `out_count`=4 when enabled.
- Single element 32'hC0400000 (−3.0) with last → `out_sum`=32'hC0400000 at T+17.
- Elements 1.0, 1.0, 1.0 separated by 2 idle cycles each, last on the third → `out_sum`=32'h40400000 (3.0).
- 10 × 0.5 consecutive, last on the tenth; then offer `in_valid` at T+3 → `out_sum`=32'h40A00000 (5.0), `drop_err`=1, result unaffected.
- Reset asserted at T+5 of a vector → `out_valid`=0 and `in_ready`=1 immediately. A following vector {2.0, 2.0} → `out_sum`=32'h40800000 (4.0), with no stale contribution.
- Two back-to-back vectors {1.0} and {8.0, 8.0} with the second starting the cycle after the first `out_valid` → sums 32'h3F800000, then 32'h41800000.
